// File: rtl/datapath_unit.sv
// rtl/datapath_unit.sv - register file, data RAM and ALU executing controller micro-ops
module datapath_unit #(
  parameter int DATA_W     = 16,
  parameter int RF_DEPTH   = 16,
  parameter int DMEM_DEPTH = 256,
  localparam int RF_AW     = $clog2(RF_DEPTH),
  localparam int DM_AW     = $clog2(DMEM_DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DM_AW-1:0]  D_Addr,
  input  logic              D_Wr,
  input  logic              RF_s,
  input  logic [RF_AW-1:0]  RF_W_Addr,
  input  logic              RF_W_en,
  input  logic [RF_AW-1:0]  RF_Ra_Addr,
  input  logic [RF_AW-1:0]  RF_Rb_Addr,
  input  logic [2:0]        ALU_s0,
  output logic [DATA_W-1:0] Ra_Data,
  output logic [DATA_W-1:0] Rb_Data,
  output logic [DATA_W-1:0] D_Rdata,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              ALU_Zero
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_PASS = 3'b110,
    OP_INC  = 3'b111
  } alu_op_e;

  logic [DATA_W-1:0] rf_q [RF_DEPTH];
  logic [DATA_W-1:0] rf_d [RF_DEPTH];
  logic [DATA_W-1:0] mem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] d_rdata_d;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_y;

  // Asynchronous register reads; no bypass, so a same-cycle write is seen after the edge
  assign Ra_Data  = rf_q[RF_Ra_Addr];
  assign Rb_Data  = rf_q[RF_Rb_Addr];
  assign D_Rdata  = d_rdata_q;
  assign ALU_Out  = alu_y;
  assign ALU_Zero = (alu_y == '0);

  // ALU: all arithmetic wraps modulo 2^DATA_W, carry discarded
  always_comb begin
    alu_y = '0;
    case (alu_op_e'(ALU_s0))
      OP_ADD:  alu_y = Ra_Data + Rb_Data;
      OP_SUB:  alu_y = Ra_Data - Rb_Data;
      OP_AND:  alu_y = Ra_Data & Rb_Data;
      OP_OR:   alu_y = Ra_Data | Rb_Data;
      OP_XOR:  alu_y = Ra_Data ^ Rb_Data;
      OP_NOT:  alu_y = ~Ra_Data;
      OP_PASS: alu_y = Ra_Data;
      OP_INC:  alu_y = Ra_Data + {{(DATA_W-1){1'b0}}, 1'b1};
      default: alu_y = '0;
    endcase
  end

  // Next register-file contents; LOAD takes the RAM word registered on the previous edge
  always_comb begin
    rf_wdata = RF_s ? d_rdata_q : alu_y;
    rf_d     = rf_q;
    if (RF_W_en) begin
      rf_d[RF_W_Addr] = rf_wdata;
    end
  end

  // RAM read port: old contents are returned when reading the address being written
  always_comb begin
    d_rdata_d = mem_q[D_Addr];
  end

  // Register file and read-data register, both cleared by reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
      d_rdata_q <= '0;
    end else begin
      rf_q      <= rf_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // RAM array: never cleared, store data always comes from read port A
  always_ff @(posedge Clk) begin
    if (!Reset && D_Wr) begin
      mem_q[D_Addr] <= Ra_Data;
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// tb/tb_datapath_unit.sv - directed vector bench for datapath_unit
module tb_datapath_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic [15:0] Ra_Data;
  logic [15:0] Rb_Data;
  logic [15:0] D_Rdata;
  logic [15:0] ALU_Out;
  logic        ALU_Zero;

  int checks = 0;
  int errors = 0;

  datapath_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .D_Addr     (D_Addr),
    .D_Wr       (D_Wr),
    .RF_s       (RF_s),
    .RF_W_Addr  (RF_W_Addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_s0     (ALU_s0),
    .Ra_Data    (Ra_Data),
    .Rb_Data    (Rb_Data),
    .D_Rdata    (D_Rdata),
    .ALU_Out    (ALU_Out),
    .ALU_Zero   (ALU_Zero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic        rfs;
    logic [3:0]  wa;
    logic        we;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  op;
    logic [15:0] e_ra;
    logic [15:0] e_rb;
    logic [15:0] e_alu;
    logic        e_z;
    logic        chk_rd;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [7:0] addr, input logic wr, input logic rfs,
                              input logic [3:0] wa, input logic we, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [2:0] op,
                              input logic [15:0] e_ra, input logic [15:0] e_rb,
                              input logic [15:0] e_alu, input logic e_z,
                              input logic chk_rd, input logic [15:0] e_rd);
    vec_t v;
    v.addr = addr; v.wr = wr; v.rfs = rfs; v.wa = wa; v.we = we;
    v.ra = ra; v.rb = rb; v.op = op;
    v.e_ra = e_ra; v.e_rb = e_rb; v.e_alu = e_alu; v.e_z = e_z;
    v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic drive(input logic [7:0] addr, input logic wr, input logic rfs,
                       input logic [3:0] wa, input logic we, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [2:0] op);
    D_Addr = addr; D_Wr = wr; RF_s = rfs; RF_W_Addr = wa; RF_W_en = we;
    RF_Ra_Addr = ra; RF_Rb_Addr = rb; ALU_s0 = op;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rf_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      RF_Ra_Addr = 4'(i);
      RF_Rb_Addr = 4'(15 - i);
      #1;
      check($sformatf("%s_ra%0d", name, i), Ra_Data, 16'h0000);
      check($sformatf("%s_rb%0d", name, 15 - i), Rb_Data, 16'h0000);
    end
  endtask

  // Build a constant in register r using only ADD (doubling) and INC, starting from R0 = 0
  task automatic build_const(input logic [3:0] r, input logic [15:0] value);
    drive(8'h00, 1'b0, 1'b0, r, 1'b1, 4'd0, 4'd0, 3'b110);
    tick();
    for (int i = 15; i >= 0; i--) begin
      drive(8'h00, 1'b0, 1'b0, r, 1'b1, r, r, 3'b000);
      tick();
      if (value[i]) begin
        drive(8'h00, 1'b0, 1'b0, r, 1'b1, r, 4'd0, 3'b111);
        tick();
      end
    end
    drive(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, r, 4'd0, 3'b110);
    #1;
    check($sformatf("const_r%0d", r), Ra_Data, value);
  endtask

  initial begin
    vecs[0]  = mk(8'h00, 0, 0, 4'd1, 1, 4'd0, 4'd0, 3'd7, 16'h0000, 16'h0000, 16'h0001, 0, 0, 16'h0000);
    vecs[1]  = mk(8'h00, 0, 0, 4'd2, 1, 4'd1, 4'd1, 3'd0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 16'h0000);
    vecs[2]  = mk(8'h00, 0, 0, 4'd3, 1, 4'd2, 4'd1, 3'd0, 16'h0002, 16'h0001, 16'h0003, 0, 0, 16'h0000);
    vecs[3]  = mk(8'h00, 0, 0, 4'd5, 1, 4'd3, 4'd2, 3'd0, 16'h0003, 16'h0002, 16'h0005, 0, 0, 16'h0000);
    vecs[4]  = mk(8'h01, 1, 0, 4'd0, 0, 4'd5, 4'd0, 3'd0, 16'h0005, 16'h0000, 16'h0005, 0, 0, 16'h0000);
    vecs[5]  = mk(8'h02, 1, 0, 4'd0, 0, 4'd3, 4'd0, 3'd0, 16'h0003, 16'h0000, 16'h0003, 0, 0, 16'h0000);
    vecs[6]  = mk(8'h01, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0005);
    vecs[7]  = mk(8'h02, 0, 1, 4'd1, 1, 4'd0, 4'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0003);
    vecs[8]  = mk(8'h01, 0, 1, 4'd2, 1, 4'd1, 4'd2, 3'd0, 16'h0005, 16'h0002, 16'h0007, 0, 1, 16'h0005);
    vecs[9]  = mk(8'h01, 0, 0, 4'd3, 1, 4'd1, 4'd2, 3'd0, 16'h0005, 16'h0003, 16'h0008, 0, 1, 16'h0005);
    vecs[10] = mk(8'h01, 0, 0, 4'd3, 1, 4'd1, 4'd2, 3'd1, 16'h0005, 16'h0003, 16'h0002, 0, 1, 16'h0005);
    vecs[11] = mk(8'h01, 0, 0, 4'd0, 0, 4'd3, 4'd0, 3'd6, 16'h0002, 16'h0000, 16'h0002, 0, 1, 16'h0005);
    vecs[12] = mk(8'h01, 0, 0, 4'd0, 0, 4'd1, 4'd2, 3'd2, 16'h0005, 16'h0003, 16'h0001, 0, 1, 16'h0005);
    vecs[13] = mk(8'h01, 0, 0, 4'd0, 0, 4'd1, 4'd2, 3'd3, 16'h0005, 16'h0003, 16'h0007, 0, 1, 16'h0005);
    vecs[14] = mk(8'h01, 0, 0, 4'd0, 0, 4'd1, 4'd2, 3'd4, 16'h0005, 16'h0003, 16'h0006, 0, 1, 16'h0005);
    vecs[15] = mk(8'h01, 0, 0, 4'd0, 0, 4'd1, 4'd2, 3'd5, 16'h0005, 16'h0003, 16'hFFFA, 0, 1, 16'h0005);
    vecs[16] = mk(8'h01, 0, 0, 4'd6, 1, 4'd0, 4'd0, 3'd5, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 16'h0005);
    vecs[17] = mk(8'h01, 0, 0, 4'd7, 1, 4'd6, 4'd0, 3'd7, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 16'h0005);
    vecs[18] = mk(8'h01, 0, 0, 4'd8, 1, 4'd0, 4'd0, 3'd7, 16'h0000, 16'h0000, 16'h0001, 0, 1, 16'h0005);
    vecs[19] = mk(8'h01, 0, 0, 4'd9, 1, 4'd6, 4'd8, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 16'h0005);
    vecs[20] = mk(8'h01, 0, 0, 4'd0, 0, 4'd0, 4'd8, 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 0, 1, 16'h0005);

    // Reset state
    Reset = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000);
    tick();
    tick();
    Reset = 1'b0;
    check("reset_drdata", D_Rdata, 16'h0000);
    check("reset_zero_add", {15'd0, ALU_Zero}, 16'h0001);
    check_rf_zero("reset");

    // Vector table: comb outputs before the edge, registered read after it
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].addr, vecs[i].wr, vecs[i].rfs, vecs[i].wa, vecs[i].we,
            vecs[i].ra, vecs[i].rb, vecs[i].op);
      #1;
      check($sformatf("v%0d_ra", i), Ra_Data, vecs[i].e_ra);
      check($sformatf("v%0d_rb", i), Rb_Data, vecs[i].e_rb);
      check($sformatf("v%0d_alu", i), ALU_Out, vecs[i].e_alu);
      check($sformatf("v%0d_zero", i), {15'd0, ALU_Zero}, {15'd0, vecs[i].e_z});
      tick();
      if (vecs[i].chk_rd) begin
        check($sformatf("v%0d_drdata", i), D_Rdata, vecs[i].e_rd);
      end
    end

    // STORE then LOAD through address 0x80
    build_const(4'd10, 16'h1234);
    drive(8'h80, 1'b1, 1'b0, 4'd0, 1'b0, 4'd10, 4'd0, 3'b000);
    tick();
    drive(8'h80, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000);
    tick();
    check("store_readback", D_Rdata, 16'h1234);
    drive(8'h33, 1'b0, 1'b1, 4'd4, 1'b1, 4'd4, 4'd0, 3'b000);
    tick();
    drive(8'h33, 1'b0, 1'b0, 4'd0, 1'b0, 4'd4, 4'd0, 3'b110);
    #1;
    check("load_r4", Ra_Data, 16'h1234);

    // Same-edge write and read of 0x10 returns the old word
    build_const(4'd11, 16'hAAAA);
    build_const(4'd12, 16'h5555);
    drive(8'h10, 1'b1, 1'b0, 4'd0, 1'b0, 4'd11, 4'd0, 3'b000);
    tick();
    drive(8'h10, 1'b1, 1'b0, 4'd0, 1'b0, 4'd12, 4'd0, 3'b000);
    tick();
    check("rbw_old", D_Rdata, 16'hAAAA);
    drive(8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000);
    tick();
    check("rbw_new", D_Rdata, 16'h5555);

    // Simultaneous RF write and STORE from the same register (R5 = 5)
    drive(8'h20, 1'b1, 1'b0, 4'd5, 1'b1, 4'd5, 4'd0, 3'b111);
    #1;
    check("sim_ra_pre", Ra_Data, 16'h0005);
    check("sim_alu_pre", ALU_Out, 16'h0006);
    tick();
    check("sim_ra_post", Ra_Data, 16'h0006);
    drive(8'h20, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 3'b000);
    tick();
    check("sim_ram_old", D_Rdata, 16'h0005);

    // Reset mid-LOAD: RF write and RAM write both suppressed
    drive(8'h80, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000);
    tick();
    check("pre_reset_drdata", D_Rdata, 16'h1234);
    Reset = 1'b1;
    drive(8'h80, 1'b1, 1'b1, 4'd13, 1'b1, 4'd5, 4'd0, 3'b000);
    tick();
    Reset = 1'b0;
    drive(8'h80, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000);
    #1;
    check("midload_drdata", D_Rdata, 16'h0000);
    check_rf_zero("midload");
    tick();
    check("ram_retained", D_Rdata, 16'h1234);
    drive(8'h10, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'b000);
    tick();
    check("ram_retained_10", D_Rdata, 16'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
